// File: rtl/core_alu_issue_pkg.sv
// Shared constants for the decode-and-issue stage: ALU op codes, RV32I opcodes, funct7 values,
// widths, buffer state type and a funct3-to-ALU-op helper.
package core_alu_issue_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ALU_OPW    = 4;
  localparam int unsigned REG_ADDR_W = 5;

  // Same encoding as the alu execution unit parameters
  localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OPW-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OPW-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OPW-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OPW-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OPW-1:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } buf_state_e;

  // Base (funct7 = 0) mapping shared by OP and OP-IMM
  function automatic logic [ALU_OPW-1:0] f3_to_op(input logic [2:0] f3);
    logic [ALU_OPW-1:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/core_alu_issue_decode.sv
// Combinational RV32I decode of OP, OP-IMM, LUI and AUIPC into an ALU op code and operands.
module core_alu_issue_decode
  import core_alu_issue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ALU_OPWIDTH = 4
) (
  input  logic [31:0]             instr,
  input  logic [31:0]             pc,
  input  logic [DATA_WIDTH-1:0]   rs1_data,
  input  logic [DATA_WIDTH-1:0]   rs2_data,
  output logic [ALU_OPWIDTH-1:0]  alu_op,
  output logic [DATA_WIDTH-1:0]   op_a,
  output logic [DATA_WIDTH-1:0]   op_b,
  output logic [REG_ADDR_W-1:0]   rd,
  output logic                    illegal
);

  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [ALU_OPW-1:0]    op_raw;
  logic [DATA_WIDTH-1:0] a_raw;
  logic [DATA_WIDTH-1:0] b_raw;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] shamt;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd     = instr[11:7];
  assign imm_i  = DATA_WIDTH'($signed(instr[31:20]));
  assign imm_u  = DATA_WIDTH'({instr[31:12], 12'b0});
  assign shamt  = DATA_WIDTH'(instr[24:20]);

  always_comb begin
    op_raw  = ALU_ADD;
    a_raw   = '0;
    b_raw   = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_raw = rs1_data;
        b_raw = rs2_data;
        if (f7 == F7_ZERO) begin
          op_raw = f3_to_op(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          op_raw = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          op_raw = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        a_raw  = rs1_data;
        b_raw  = imm_i;
        op_raw = f3_to_op(f3);
        // Shift immediates reuse imm[31:25] as funct7; other funct3 ignore it
        if (f3 == 3'b001) begin
          b_raw = shamt;
          if (f7 != F7_ZERO) illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          b_raw = shamt;
          if (f7 == F7_ALT) op_raw = ALU_SRA;
          else if (f7 != F7_ZERO) illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        b_raw = imm_u;
      end
      OPC_AUIPC: begin
        a_raw = DATA_WIDTH'(pc);
        b_raw = imm_u;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_op = illegal ? ALU_OPWIDTH'(ALU_ADD) : ALU_OPWIDTH'(op_raw);
  assign op_a   = illegal ? '0 : a_raw;
  assign op_b   = illegal ? '0 : b_raw;

endmodule

// File: rtl/core_alu_issue.sv
// Decode-and-issue stage: decodes one instruction per cycle and holds the result in a two-entry
// skid buffer so in_ready_o depends only on registered state.
module core_alu_issue
  import core_alu_issue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ALU_OPWIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             instr_i,
  input  logic [31:0]             pc_i,
  input  logic [DATA_WIDTH-1:0]   rs1_data_i,
  input  logic [DATA_WIDTH-1:0]   rs2_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [ALU_OPWIDTH-1:0]  alu_op_o,
  output logic [DATA_WIDTH-1:0]   op_a_o,
  output logic [DATA_WIDTH-1:0]   op_b_o,
  output logic [4:0]              rd_o,
  output logic                    illegal_o
);

  typedef struct packed {
    logic [ALU_OPWIDTH-1:0] op;
    logic [DATA_WIDTH-1:0]  a;
    logic [DATA_WIDTH-1:0]  b;
    logic [4:0]             rd;
    logic                   ill;
  } entry_t;

  buf_state_e state_q, state_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  entry_t     dec;
  logic       accept;
  logic       drain;

  core_alu_issue_decode #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ALU_OPWIDTH (ALU_OPWIDTH)
  ) u_decode (
    .instr    (instr_i),
    .pc       (pc_i),
    .rs1_data (rs1_data_i),
    .rs2_data (rs2_data_i),
    .alu_op   (dec.op),
    .op_a     (dec.a),
    .op_b     (dec.b),
    .rd       (dec.rd),
    .illegal  (dec.ill)
  );

  assign in_ready_o  = (state_q != StFull);
  assign out_valid_o = (state_q != StEmpty);
  assign accept      = in_valid_i && in_ready_o;
  assign drain       = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = dec;
          state_d = StOne;
        end
      end
      StOne: begin
        case ({accept, drain})
          2'b10: begin
            skid_d  = dec;
            state_d = StFull;
          end
          2'b01: state_d = StEmpty;
          2'b11: main_d = dec;
          default: ;
        endcase
      end
      StFull: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over a same-cycle accept; loaded data is ignored since state goes empty
    if (flush_i) state_d = StEmpty;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign alu_op_o  = main_q.op;
  assign op_a_o    = main_q.a;
  assign op_b_o    = main_q.b;
  assign rd_o      = main_q.rd;
  assign illegal_o = main_q.ill;

endmodule
